// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
//   fetch_state_t : fetch FSM states
//   if_id_t       : one IF/ID slot (valid, pc, instr)
//   RESET_VECTOR  : PC after reset (reset value of if_id_pc)
//   NOP_INSTR     : addi x0,x0,0, shown in empty slots
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0060;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an IF/ID slot. Catches the instruction
// returned by memory while ID is stalled.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture data_in
//   clear    : invalidate the entry (wins over load)
//   data_in  : slot to capture
//   data_out : held slot
//   valid    : entry holds an instruction
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  if_id_t data_in,
  output if_id_t data_out,
  output logic   valid
);

  if_id_t entry;

  // NOTE: only the valid bit is reset; the payload is meaningless while
  // valid is low, so it is left without a reset.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry.valid <= 1'b0;
    end else if (clear) begin
      entry.valid <= 1'b0;
    end else if (load) begin
      entry <= data_in;
    end
  end

  assign data_out = entry;
  assign valid    = entry.valid;

endmodule

// File: rtl/fetch_unit.sv
// IF stage of the RV32I pipeline. Issues instruction-memory reads at the
// PC supplied by the PC register, fills the IF/ID register, advances or
// redirects the PC, absorbs ID back-pressure with a one-entry skid buffer
// and squashes a read still in flight when EX redirects.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pc_in             : current PC from the PC register
//   pc_load, pc_next  : PC register load strobe / value
//   imem_read/addr    : read request, held until imem_resp
//   imem_rdata/resp   : returned instruction, one-cycle response strobe
//   stall_in          : ID cannot accept; if_id_* hold
//   redirect_valid/target : EX taken branch or jump
//   if_id_valid/pc/instr  : IF/ID slot (instr is NOP when invalid)
//   if_id_misaligned  : slot is a misaligned-fetch marker (macro builds only)
//
// Build option: define FETCH_MISALIGN_CHECK_EN to refuse fetches from a
// PC with pc[1:0] != 0; a NOP marked misaligned is placed in the slot and
// the unit waits for a redirect.
module fetch_unit #(
  parameter int unsigned      WIDTH        = fetch_pkg::XLEN,
  parameter logic [WIDTH-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR,
  parameter logic [WIDTH-1:0] NOP_INSTR    = fetch_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_resp,
  input  logic             stall_in,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             if_id_valid,
  output logic [WIDTH-1:0] if_id_pc,
  output logic [WIDTH-1:0] if_id_instr
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic             if_id_misaligned
`endif
);

  import fetch_pkg::*;

  fetch_state_t     state, state_next;
  if_id_t           if_id_q, if_id_d;
  if_id_t           skid_q, skid_d;
  logic             skid_load, skid_clear, skid_valid;
  logic [WIDTH-1:0] drain_addr, drain_addr_d;
  logic             slot_free;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misal_q, misal_d;
  // Set once the misaligned marker has been written, so it is not
  // re-issued every cycle while waiting for the redirect.
  logic misal_wait_q, misal_wait_d;
`endif

  assign skid_d = '{valid: 1'b1, pc: pc_in, instr: imem_rdata};

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .data_in  (skid_d),
    .data_out (skid_q),
    .valid    (skid_valid)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    slot_free    = !if_id_q.valid || !stall_in;
    state_next   = state;
    pc_load      = 1'b0;
    pc_next      = pc_in + WIDTH'(4);
    imem_read    = 1'b0;
    imem_addr    = pc_in;
    if_id_d      = if_id_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    drain_addr_d = drain_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
    misal_d      = misal_q;
    misal_wait_d = misal_wait_q;
`endif

    // ID takes the slot this cycle: leave a bubble unless refilled below.
    if (if_id_q.valid && !stall_in) begin
      if_id_d.valid = 1'b0;
    end

    case (state)
      IDLE: state_next = FETCH;

      FETCH: begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (pc_in[1:0] != 2'b00) begin
          if (slot_free && !misal_wait_q) begin
            if_id_d      = '{valid: 1'b1, pc: pc_in, instr: NOP_INSTR};
            misal_d      = 1'b1;
            misal_wait_d = 1'b1;
          end
        end else
`endif
        begin
          imem_read = 1'b1;
          if (imem_resp) begin
            pc_load = 1'b1;
            if (slot_free) begin
              if_id_d = '{valid: 1'b1, pc: pc_in, instr: imem_rdata};
`ifdef FETCH_MISALIGN_CHECK_EN
              misal_d = 1'b0;
`endif
            end else begin
              skid_load  = 1'b1;
              state_next = HOLD;
            end
          end
        end
      end

      HOLD: begin
        if (!skid_valid) begin
          state_next = FETCH;
        end else if (!stall_in) begin
          if_id_d    = skid_q;
          skid_clear = 1'b1;
          state_next = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
          misal_d    = 1'b0;
`endif
        end
      end

      DRAIN: begin
        // Keep the squashed request alive until memory answers it.
        imem_read = 1'b1;
        imem_addr = drain_addr;
        if (imem_resp) begin
          state_next = FETCH;
        end
      end

      default: state_next = IDLE;
    endcase

    // Redirect overrides everything above, including stall_in.
    if (redirect_valid) begin
      pc_load       = 1'b1;
      pc_next       = redirect_target;
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
      skid_load     = 1'b0;
      skid_clear    = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      misal_d       = 1'b0;
      misal_wait_d  = 1'b0;
`endif
      case (state)
        FETCH: begin
          if (imem_read && !imem_resp) begin
            drain_addr_d = imem_addr;
            state_next   = DRAIN;
          end else begin
            state_next = FETCH;
          end
        end
        DRAIN:   ;
        default: state_next = FETCH;
      endcase
    end

    if (rst) begin
      pc_load   = 1'b0;
      imem_read = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      if_id_q    <= '{valid: 1'b0, pc: RESET_VECTOR, instr: NOP_INSTR};
      drain_addr <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misal_q      <= 1'b0;
      misal_wait_q <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      if_id_q    <= if_id_d;
      drain_addr <= drain_addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misal_q      <= misal_d;
      misal_wait_q <= misal_wait_d;
`endif
    end
  end

  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.valid ? if_id_q.instr : NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign if_id_misaligned = if_id_q.valid && misal_q;
`endif

endmodule
